sha256_round_ctrl: RTL and testbench
====================================

# sha256_round_ctrl

Sequencing controller for the SHA-256 compression datapath. It takes one 512-bit block through IV load, working-register initialisation, 64 rounds and the final H accumulation. It drives the load/update controls of the a..h working registers (the `control` input of each register slice) and the H0..H7 update. It also paces message-word intake for rounds 0–15 with a valid/ready handshake.

## Interface
Parameters:
- NUM_ROUNDS, 64: rounds per block. Fixed by SHA-256 and not intended to be overridden.
- MSG_ROUNDS, 16: leading rounds that consume external message words.

Ports:
- clk  in  1  single clock; all state updates on the posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to process one block. Sampled only in IDLE.
- first_block  in  1  sampled together with an accepted start. 1 means H0..H7 must be loaded with the FIPS 180-4 IV first.
- msg_valid  in  1  message word M_t present on the datapath input.
- msg_ready  out  1  controller is consuming message words (ROUND state with round < 16).
- iv_load  out  1  load H0..H7 with the IV.
- init  out  1  load a..h from H0..H7. This drives the working registers' control=1 path.
- round_en  out  1  a..h take the round update, e.g. e <= T1 + d.
- round  out  6  current round index t. Also the K-ROM address.
- w_src  out  1  1 means W_t = M_t; 0 means W_t comes from the expanded schedule.
- h_update  out  1  H_i <= H_i + working variable i.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

## Operation
- State is registered and all outputs are Moore-decoded from state/round, except round_en.
- The states are IDLE, LOAD_IV, INIT, ROUND, UPDATE and DONE.
- **IDLE:** on start=1, latch first_block.
  - Go to LOAD_IV if first_block=1.
  - Otherwise go to INIT.
- **LOAD_IV:** iv_load=1 for one cycle, then go to INIT.
- **INIT:** init=1 for one cycle. Clear round to 0, then go to ROUND.
- **ROUND:**
  - round_en = (round >= 16) | msg_valid.
  - msg_ready = (round < 16).
  - w_src = (round < 16).
  - When round_en=1, round increments.
  - When round=63 and round_en=1, round wraps to 0 and the state goes to UPDATE.
  - With round < 16 and msg_valid=0, the round stalls: round holds and round_en=0.
- **UPDATE:** h_update=1 for one cycle, then go to DONE.
- **DONE:** done=1 for one cycle, then go to IDLE.
- start is ignored in every state except IDLE, including DONE. A level-held start is accepted on the first IDLE cycle.
- round is 0 in every state except ROUND.
- msg_valid is ignored outside ROUND or when round >= 16.
- Reset:
  - All outputs are 0 and round=0 after the reset edge. The state is IDLE and the latched first_block is 0.
  - rst overrides start.
  - rst mid-block aborts with no h_update and no done. Partial H/a..h contents are not the controller's concern.

## Timing
- Cycle 0 is the edge where start=1 is sampled in IDLE.
- First block without stalls:
  - iv_load at cycle 1.
  - init at cycle 2.
  - round_en at cycles 3–66 with round=0..63.
  - h_update at cycle 67.
  - done at cycle 68.
  - IDLE from cycle 69.
- Non-first block: the same sequence shifted one cycle earlier. init at cycle 1, done at cycle 67.
- Each stall cycle (round < 16, msg_valid=0) delays all later events by exactly one cycle.
- Latency from start to done is 68 cycles for a first block and 67 for a subsequent block, plus the number of stall cycles.
- Throughput with start held high is one block per 69 (first) or 68 (subsequent) cycles. The extra cycle is the IDLE cycle.
- At most one of iv_load, init, round_en, h_update and done is high in any cycle.

## Test plan
- **Reset, then first block:** rst=1 for 2 cycles, then start=1 with first_block=1 and msg_valid held 1.
  - Required: iv_load@1, init@2, round_en at 3..66 with round 0..63, w_src=1 exactly at rounds 0..15, h_update@67, done@68, busy=1 over cycles 1..68.
- **Non-first block:** start=1 with first_block=0.
  - Required: no iv_load, init@1, done@67.
- **Message stalls:** drop msg_valid for 3 cycles while round=5 and for 1 cycle at round=15. Also drop it at round=20.
  - Required: round holds at 5 for 3 cycles and at 15 for 1 cycle, with round_en=0 during those cycles.
  - Required: the drop at round=20 has no effect.
  - Required: done@71.
- **start while busy:** pulse start at cycles 10 and 40 of a block, and hold start=1 through DONE.
  - Required: the pulses are ignored.
  - Required: the held start is accepted in the first IDLE cycle (69) and the next init fires @70 (first_block=0).
- **Reset mid-operation:** assert rst at round=30.
  - Required: next cycle state is IDLE, all outputs 0, round=0, and no h_update or done.
  - Required: a subsequent start runs a full, correct sequence.
- **Exclusivity:** a random msg_valid/start run of ≥20 blocks.
  - Required: checker confirms the one-hot property of iv_load, init, round_en, h_update and done.
  - Required: exactly 64 round_en pulses and one h_update per accepted start.

Source files
------------

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: IV load, working-register init, 64 rounds and H accumulation
// for one 512-bit block, with valid/ready pacing of message words during rounds 0..15.
`timescale 1ns/1ps
module sha256_round_ctrl #(
  parameter int NUM_ROUNDS = 64,
  parameter int MSG_ROUNDS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       first_block,
  input  logic       msg_valid,
  output logic       msg_ready,
  output logic       iv_load,
  output logic       init,
  output logic       round_en,
  output logic [5:0] round,
  output logic       w_src,
  output logic       h_update,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_IV = 3'd1,
    S_INIT    = 3'd2,
    S_ROUND   = 3'd3,
    S_UPDATE  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);
  localparam logic [5:0] MSG_LIMIT  = 6'(MSG_ROUNDS);

  state_t     state_r, state_s;
  logic [5:0] round_r, round_s;
  logic       first_r, first_s;
  logic       msg_phase_s;
  logic       step_s;

  // State, round counter and latched first_block registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      round_r <= 6'd0;
      first_r <= 1'b0;
    end else begin
      state_r <= state_s;
      round_r <= round_s;
      first_r <= first_s;
    end
  end

  // Next-state and round-advance logic; a round only advances once its word is available
  always_comb begin
    state_s     = state_r;
    round_s     = round_r;
    first_s     = first_r;
    step_s      = 1'b0;
    msg_phase_s = (round_r < MSG_LIMIT);
    case (state_r)
      S_IDLE: begin
        round_s = 6'd0;
        if (start) begin
          first_s = first_block;
          state_s = first_block ? S_LOAD_IV : S_INIT;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD_IV: state_s = S_INIT;
      S_INIT: begin
        round_s = 6'd0;
        state_s = S_ROUND;
      end
      S_ROUND: begin
        step_s = !msg_phase_s || msg_valid;
        if (step_s) begin
          if (round_r == LAST_ROUND) begin
            round_s = 6'd0;
            state_s = S_UPDATE;
          end else begin
            round_s = round_r + 6'd1;
          end
        end else begin
          round_s = round_r;
        end
      end
      S_UPDATE: state_s = S_DONE;
      S_DONE:   state_s = S_IDLE;
      default: begin
        state_s = S_IDLE;
        round_s = 6'd0;
      end
    endcase
  end

  // Output decode from the registered state; round_en alone also depends on msg_valid
  always_comb begin
    iv_load   = 1'b0;
    init      = 1'b0;
    round_en  = 1'b0;
    msg_ready = 1'b0;
    w_src     = 1'b0;
    h_update  = 1'b0;
    done      = 1'b0;
    busy      = (state_r != S_IDLE);
    round     = round_r;
    case (state_r)
      S_LOAD_IV: iv_load = 1'b1;
      S_INIT:    init    = 1'b1;
      S_ROUND: begin
        round_en  = step_s;
        msg_ready = msg_phase_s;
        w_src     = msg_phase_s;
      end
      S_UPDATE:  h_update = 1'b1;
      S_DONE:    done     = 1'b1;
      default:   iv_load  = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed self-checking bench for sha256_round_ctrl: per-cycle output vectors against
// hand-derived timelines, plus a randomised multi-block run for exclusivity and round counts.
`timescale 1ns/1ps
module tb_sha256_round_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, first_block, msg_valid;
  logic       msg_ready, iv_load, init, round_en, w_src, h_update, busy, done;
  logic [5:0] round;

  int errors = 0;
  int checks = 0;

  // Per-cycle stimulus schedules (index = cycle after the start edge) and recorded outputs
  bit          start_at [0:199];
  bit          fb_at    [0:199];
  bit          drop_at  [0:199];
  bit          rst_at   [0:199];
  bit          stall_at [0:199];
  logic [13:0] rec      [0:199];

  sha256_round_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .first_block(first_block), .msg_valid(msg_valid),
    .msg_ready(msg_ready), .iv_load(iv_load), .init(init), .round_en(round_en), .round(round),
    .w_src(w_src), .h_update(h_update), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // {iv_load, init, round_en, h_update, done, busy, w_src, msg_ready, round[5:0]}
  function automatic logic [13:0] obs_vec();
    return {iv_load, init, round_en, h_update, done, busy, w_src, msg_ready, round};
  endfunction

  // Expected vector at cycle k of a block whose init fires at c_init, using stall_at
  function automatic logic [13:0] exp_vec(input int k, input int c_init, input bit fb);
    int tot = 0;
    int ns = 0;
    int c_hu;
    bit in_round;
    logic [5:0] rnd;
    for (int j = 0; j < 200; j++) begin
      if (stall_at[j]) begin
        tot++;
        if (j > c_init && j < k) ns++;
      end
    end
    c_hu     = c_init + 65 + tot;
    in_round = (k > c_init) && (k < c_hu);
    rnd      = in_round ? 6'(k - c_init - 1 - ns) : 6'd0;
    return {fb && (k == c_init - 1), k == c_init, in_round && !stall_at[k], k == c_hu,
            k == c_hu + 1, (k >= (fb ? c_init - 1 : c_init)) && (k <= c_hu + 1),
            in_round && (rnd < 6'd16), in_round && (rnd < 6'd16), rnd};
  endfunction

  task automatic clear_stim();
    for (int i = 0; i < 200; i++) begin
      start_at[i] = 1'b0; fb_at[i] = 1'b0; drop_at[i] = 1'b0;
      rst_at[i] = 1'b0; stall_at[i] = 1'b0; rec[i] = 14'd0;
    end
  endtask

  // Starts a block on the next edge, records ncyc cycles, then drains back to IDLE
  task automatic run_seq(input int ncyc, input bit fb);
    int n = 0;
    start = 1'b1; first_block = fb; msg_valid = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk); #1;
      start = start_at[k]; first_block = fb_at[k]; msg_valid = !drop_at[k]; rst = rst_at[k];
      @(negedge clk);
      rec[k] = obs_vec();
    end
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0; msg_valid = 1'b1; first_block = 1'b0;
    while (busy && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout busy=%b required=0", busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; first_block = 1'b1; msg_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (obs_vec() !== 14'd0) begin
        errors++;
        $display("FAIL reset_hold edge=%0d got=%b required=%b", i, obs_vec(), 14'd0);
      end
    end
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs_vec() !== 14'd0) begin
      errors++;
      $display("FAIL reset_idle got=%b required=%b", obs_vec(), 14'd0);
    end
  endtask

  task automatic test_first_block();
    clear_stim();
    run_seq(70, 1'b1);
    for (int k = 1; k <= 70; k++) begin
      checks++;
      if (rec[k] !== exp_vec(k, 2, 1'b1)) begin
        errors++;
        $display("FAIL first_block cyc=%0d got=%b required=%b", k, rec[k], exp_vec(k, 2, 1'b1));
      end
    end
  endtask

  task automatic test_non_first_block();
    clear_stim();
    run_seq(68, 1'b0);
    for (int k = 1; k <= 68; k++) begin
      checks++;
      if (rec[k] !== exp_vec(k, 1, 1'b0)) begin
        errors++;
        $display("FAIL non_first cyc=%0d got=%b required=%b", k, rec[k], exp_vec(k, 1, 1'b0));
      end
    end
  endtask

  task automatic test_msg_stalls();
    clear_stim();
    // round 5 sits at cycles 7..9, round 15 at cycle 20, round 20 at cycle 26
    drop_at[7] = 1'b1; drop_at[8] = 1'b1; drop_at[9] = 1'b1; drop_at[20] = 1'b1; drop_at[26] = 1'b1;
    stall_at[7] = 1'b1; stall_at[8] = 1'b1; stall_at[9] = 1'b1; stall_at[20] = 1'b1;
    run_seq(72, 1'b0);
    for (int k = 1; k <= 72; k++) begin
      checks++;
      if (rec[k] !== exp_vec(k, 1, 1'b0)) begin
        errors++;
        $display("FAIL msg_stall cyc=%0d got=%b required=%b", k, rec[k], exp_vec(k, 1, 1'b0));
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [13:0] want70;
    clear_stim();
    start_at[10] = 1'b1; fb_at[10] = 1'b1;
    start_at[40] = 1'b1; fb_at[40] = 1'b1;
    for (int k = 60; k <= 69; k++) start_at[k] = 1'b1;
    run_seq(70, 1'b1);
    for (int k = 1; k <= 69; k++) begin
      checks++;
      if (rec[k] !== exp_vec(k, 2, 1'b1)) begin
        errors++;
        $display("FAIL busy_start cyc=%0d got=%b required=%b", k, rec[k], exp_vec(k, 2, 1'b1));
      end
    end
    want70 = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0};
    checks++;
    if (rec[70] !== want70) begin
      errors++;
      $display("FAIL held_start_init cyc=70 got=%b required=%b", rec[70], want70);
    end
  endtask

  task automatic test_reset_mid_block();
    logic [13:0] want;
    clear_stim();
    rst_at[32] = 1'b1;
    run_seq(100, 1'b0);
    for (int k = 1; k <= 100; k++) begin
      want = (k <= 32) ? exp_vec(k, 1, 1'b0) : 14'd0;
      checks++;
      if (rec[k] !== want) begin
        errors++;
        $display("FAIL reset_mid cyc=%0d got=%b required=%b", k, rec[k], want);
      end
    end
    clear_stim();
    run_seq(68, 1'b0);
    for (int k = 1; k <= 68; k++) begin
      checks++;
      if (rec[k] !== exp_vec(k, 1, 1'b0)) begin
        errors++;
        $display("FAIL after_reset cyc=%0d got=%b required=%b", k, rec[k], exp_vec(k, 1, 1'b0));
      end
    end
  endtask

  task automatic test_exclusivity();
    int accepted = 0;
    int hu = 0;
    int viol = 0;
    int re_cnt = 0;
    int cyc = 0;
    logic [4:0] ctl;
    while ((accepted < 20 || busy) && cyc < 8000) begin
      start       = (accepted < 20) ? ($urandom_range(1, 0) == 1) : 1'b0;
      first_block = ($urandom_range(1, 0) == 1);
      msg_valid   = ($urandom_range(3, 0) != 0);
      @(negedge clk);
      ctl = {iv_load, init, round_en, h_update, done};
      if ($countones(ctl) > 1) viol++;
      if (!busy && start) begin
        accepted++;
        re_cnt = 0;
      end
      if (round_en) re_cnt++;
      if (h_update) begin
        hu++;
        checks++;
        if (re_cnt !== 64) begin
          errors++;
          $display("FAIL round_en_count block=%0d got=%0d required=64", hu, re_cnt);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; msg_valid = 1'b1;
    checks++;
    if (accepted !== 20) begin
      errors++;
      $display("FAIL rand_accepted got=%0d required=20 cycles=%0d", accepted, cyc);
    end
    checks++;
    if (hu !== accepted) begin
      errors++;
      $display("FAIL rand_h_update got=%0d required=%0d", hu, accepted);
    end
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL one_hot violations=%0d required=0", viol);
    end
  endtask

  initial begin
    clear_stim();
    test_reset();
    test_first_block();
    test_non_first_block();
    test_msg_stalls();
    test_start_while_busy();
    test_reset_mid_block();
    test_exclusivity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
